// File: rtl/axi_lite_slave_regs_if.sv
// AXI4-Lite bus bundle shared by register-file responders and their requesters.
`timescale 1ns/1ps
interface axi_lite_slave_regs_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] AWADDR;
  logic                  AWVALID;
  logic                  AWREADY;
  logic [DATA_WIDTH-1:0] WDATA;
  logic                  WVALID;
  logic                  WREADY;
  logic [1:0]            BRESP;
  logic                  BVALID;
  logic                  BREADY;
  logic [ADDR_WIDTH-1:0] ARADDR;
  logic                  ARVALID;
  logic                  ARREADY;
  logic [DATA_WIDTH-1:0] RDATA;
  logic [1:0]            RRESP;
  logic                  RVALID;
  logic                  RREADY;

  modport master (
    output AWADDR, AWVALID, WDATA, WVALID, BREADY, ARADDR, ARVALID, RREADY,
    input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
  );

  modport slave (
    input  AWADDR, AWVALID, WDATA, WVALID, BREADY, ARADDR, ARVALID, RREADY,
    output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
  );
endinterface

// File: rtl/axi_lite_slave_regs.sv
// AXI4-Lite register file: register 0 is a read-only ID, the rest are full-word R/W.
// Write address and data may arrive in either order; one write and one read in flight.
`timescale 1ns/1ps
module axi_lite_slave_regs #(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           NUM_REGS   = 8,
  parameter logic [DATA_WIDTH-1:0] ID_VALUE   = 32'hA11E_0001
) (
  input  logic                           ACLK,
  input  logic                           ARESETn,
  axi_lite_slave_regs_if.slave           s_axi,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o
);
  localparam int unsigned IDX_W       = $clog2(NUM_REGS);
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;

  typedef logic [IDX_W-1:0] idx_t;

  logic                  aw_held_q, aw_held_d;
  logic                  aw_ok_q, aw_ok_d;
  idx_t                  aw_idx_q, aw_idx_d;
  logic                  w_held_q, w_held_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  bvalid_q, bvalid_d;
  logic [1:0]            bresp_q, bresp_d;
  logic                  rvalid_q, rvalid_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]            rresp_q, rresp_d;
  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];

  logic                  aw_hs_c, w_hs_c, ar_hs_c, commit_c;
  logic                  aw_in_range_c, aw_ok_c, ar_in_range_c;
  idx_t                  aw_idx_c, ar_idx_c, wr_idx_c;
  logic                  wr_ok_c;
  logic [DATA_WIDTH-1:0] wr_data_c;
  logic [3:0]            unused_addr_lsbs;

  // Byte-lane bits carry no meaning for full-word registers.
  assign unused_addr_lsbs = {s_axi.AWADDR[1:0], s_axi.ARADDR[1:0]};

  assign aw_in_range_c = (s_axi.AWADDR[ADDR_WIDTH-1:IDX_W+2] == '0);
  assign aw_idx_c      = s_axi.AWADDR[IDX_W+1:2];
  assign aw_ok_c       = aw_in_range_c && (aw_idx_c != '0);
  assign ar_in_range_c = (s_axi.ARADDR[ADDR_WIDTH-1:IDX_W+2] == '0);
  assign ar_idx_c      = s_axi.ARADDR[IDX_W+1:2];

  assign s_axi.AWREADY = !aw_held_q && !bvalid_q;
  assign s_axi.WREADY  = !w_held_q && !bvalid_q;
  assign s_axi.ARREADY = !rvalid_q;
  assign s_axi.BVALID  = bvalid_q;
  assign s_axi.BRESP   = bresp_q;
  assign s_axi.RVALID  = rvalid_q;
  assign s_axi.RDATA   = rdata_q;
  assign s_axi.RRESP   = rresp_q;

  assign aw_hs_c   = s_axi.AWVALID && s_axi.AWREADY;
  assign w_hs_c    = s_axi.WVALID && s_axi.WREADY;
  assign ar_hs_c   = s_axi.ARVALID && s_axi.ARREADY;
  // A write commits as soon as both halves are either held or arriving now.
  assign commit_c  = (aw_held_q || aw_hs_c) && (w_held_q || w_hs_c);
  assign wr_ok_c   = aw_hs_c ? aw_ok_c  : aw_ok_q;
  assign wr_idx_c  = aw_hs_c ? aw_idx_c : aw_idx_q;
  assign wr_data_c = w_hs_c  ? s_axi.WDATA : wdata_q;

  always_comb begin
    aw_held_d = aw_held_q;
    aw_ok_d   = aw_ok_q;
    aw_idx_d  = aw_idx_q;
    w_held_d  = w_held_q;
    wdata_d   = wdata_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    regs_d    = regs_q;
    regs_d[0] = ID_VALUE;

    if (bvalid_q && s_axi.BREADY) bvalid_d = 1'b0;
    if (aw_hs_c) begin
      aw_held_d = 1'b1;
      aw_ok_d   = aw_ok_c;
      aw_idx_d  = aw_idx_c;
    end
    if (w_hs_c) begin
      w_held_d = 1'b1;
      wdata_d  = s_axi.WDATA;
    end
    if (commit_c) begin
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
      bvalid_d  = 1'b1;
      if (wr_ok_c) begin
        regs_d[wr_idx_c] = wr_data_c;
        bresp_d          = RESP_OKAY;
      end else begin
        bresp_d = RESP_SLVERR;
      end
    end

    // Reads sample the pre-edge register contents, independent of any commit.
    if (rvalid_q && s_axi.RREADY) rvalid_d = 1'b0;
    if (ar_hs_c) begin
      rvalid_d = 1'b1;
      if (ar_in_range_c) begin
        rdata_d = regs_q[ar_idx_c];
        rresp_d = RESP_OKAY;
      end else begin
        rdata_d = '0;
        rresp_d = RESP_SLVERR;
      end
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      aw_held_q <= 1'b0;
      aw_ok_q   <= 1'b0;
      aw_idx_q  <= '0;
      w_held_q  <= 1'b0;
      wdata_q   <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        regs_q[i] <= (i == 0) ? ID_VALUE : '0;
      end
    end else begin
      aw_held_q <= aw_held_d;
      aw_ok_q   <= aw_ok_d;
      aw_idx_q  <= aw_idx_d;
      w_held_q  <= w_held_d;
      wdata_q   <= wdata_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      regs_q    <= regs_d;
    end
  end

  for (genvar g = 0; g < int'(NUM_REGS); g++) begin : g_regs_o
    assign regs_o[g*DATA_WIDTH +: DATA_WIDTH] = regs_q[g];
  end
endmodule
